// File: rtl/recon_pkg.sv
// Shared types and helpers for the streaming block combiner.
//   mode_e          residual handling mode
//   state_e         block framing FSM states
//   beats_per_block beats needed to carry a square block of edge 2^size_log2
//   pix_max         largest unsigned pixel value for a given width
//   decode_mode     maps the raw 2-bit mode field; the reserved code behaves as ADD
package recon_pkg;

  typedef enum logic [1:0] {
    MODE_ADD  = 2'd0,
    MODE_SKIP = 2'd1,
    MODE_DC   = 2'd2
  } mode_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  localparam int SIZE_LOG2_MIN = 2;
  localparam int SIZE_LOG2_MAX = 5;

  function automatic logic [15:0] beats_per_block(input logic [2:0] size_log2, input int lanes);
    int pixels;
    int beats;
    pixels = 1 << (2 * int'(size_log2));
    beats  = pixels / lanes;
    if (beats < 1) beats = 1;
    return 16'(beats);
  endfunction

  function automatic int pix_max(input int pixel_width);
    return (1 << pixel_width) - 1;
  endfunction

  function automatic mode_e decode_mode(input logic [1:0] raw);
    case (raw)
      2'd1:    return MODE_SKIP;
      2'd2:    return MODE_DC;
      default: return MODE_ADD;
    endcase
  endfunction

endpackage

// File: rtl/recon_clip_lane.sv
// Single-lane reconstruction arithmetic, purely combinational.
//   pred     unsigned prediction pixel
//   resid    signed effective residual
//   sum      pred + resid at RESIDUAL_WIDTH+1 bits (registered by the caller)
//   sum_q    registered sum to be clipped
//   pix      sum_q saturated into [0, 2^PIXEL_WIDTH-1]
//   clipped  high when either saturation branch was taken
module recon_clip_lane
  import recon_pkg::*;
#(
  parameter int PIXEL_WIDTH    = 8,
  parameter int RESIDUAL_WIDTH = 12
) (
  input  logic        [PIXEL_WIDTH-1:0]  pred,
  input  logic signed [RESIDUAL_WIDTH-1:0] resid,
  output logic signed [RESIDUAL_WIDTH:0] sum,
  input  logic signed [RESIDUAL_WIDTH:0] sum_q,
  output logic        [PIXEL_WIDTH-1:0]  pix,
  output logic                           clipped
);

  localparam int SW = RESIDUAL_WIDTH + 1;
  localparam logic signed [SW-1:0] MAX_V = SW'(pix_max(PIXEL_WIDTH));

  // Prediction is zero-extended, residual sign-extended; RESIDUAL_WIDTH > PIXEL_WIDTH
  // guarantees the sum cannot overflow SW bits.
  assign sum = $signed({{(SW-PIXEL_WIDTH){1'b0}}, pred}) + $signed({resid[RESIDUAL_WIDTH-1], resid});

  always_comb begin
    pix     = sum_q[PIXEL_WIDTH-1:0];
    clipped = 1'b0;
    if (sum_q[SW-1]) begin
      pix     = '0;
      clipped = 1'b1;
    end else if (sum_q > MAX_V) begin
      pix     = '1;
      clipped = 1'b1;
    end
  end

endmodule

// File: rtl/block_combiner_stream.sv
// Streaming block combiner: reconstructs clip(P + R) for LANES pixels per beat,
// frames the output per block and reports the saturated-pixel count per block.
//   clk, reset_n          clock, asynchronous active-low reset
//   flush                 synchronous abort of the block in progress
//   cfg_size_log2/mode    block configuration, sampled on a block's first beat
//   in_valid/in_ready     input handshake; in_pred/in_resid lane 0 in LSBs
//   out_valid/out_ready   output handshake; out_pix reconstructed pixels
//   out_last              final beat of a block
//   done, clip_count      one-cycle completion pulse and the block's clip total
//
// state     | meaning
// ST_IDLE   | waiting for a block's first beat; cfg inputs are sampled on it
// ST_ACTIVE | mid-block; counting beats up to beats_per_block-1
module block_combiner_stream
  import recon_pkg::*;
#(
  parameter int MAX_BLOCK_SIZE = 32,
  parameter int LANES          = 4,
  parameter int PIXEL_WIDTH    = 8,
  parameter int RESIDUAL_WIDTH = 12
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             flush,
  input  logic [2:0]                       cfg_size_log2,
  input  logic [1:0]                       cfg_mode,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [LANES*PIXEL_WIDTH-1:0]     in_pred,
  input  logic [LANES*RESIDUAL_WIDTH-1:0]  in_resid,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [LANES*PIXEL_WIDTH-1:0]     out_pix,
  output logic                             out_last,
  output logic                             done,
  output logic [10:0]                      clip_count
);

  localparam int PW     = PIXEL_WIDTH;
  localparam int RW     = RESIDUAL_WIDTH;
  localparam int SZ_MAX = ($clog2(MAX_BLOCK_SIZE) < SIZE_LOG2_MAX) ? $clog2(MAX_BLOCK_SIZE) : SIZE_LOG2_MAX;
  localparam int BPB_W  = 2 * SZ_MAX + 1;
  localparam int NC_W   = $clog2(LANES + 1);

  state_e                state_q, state_d;
  logic [BPB_W-1:0]      bpb_q, cnt_q;
  mode_e                 mode_q;
  logic signed [RW-1:0]  dc_q;

  logic [2:0]            size_sat;
  logic [BPB_W-1:0]      bpb_eff;
  mode_e                 mode_eff;
  logic signed [RW-1:0]  dc_eff;
  logic                  first_beat, beat_last, adv, accept;

  logic signed [RW-1:0]  r_eff   [LANES];
  logic signed [RW:0]    sum_d   [LANES];
  logic signed [RW:0]    s1_sum  [LANES];
  logic [PW-1:0]         pix_d   [LANES];
  logic [PW-1:0]         s2_pix  [LANES];
  logic [LANES-1:0]      clip_d;
  logic [NC_W-1:0]       nclip_d, s2_nclip;
  logic                  s1_valid, s1_last, s2_valid, s2_last;
  logic [10:0]           acc_q;
  logic                  out_fire;

  assign adv      = !s2_valid || out_ready;
  assign in_ready = adv;
  assign accept   = in_valid && adv && !flush;
  assign out_fire = s2_valid && out_ready;

  always_comb begin
    size_sat = cfg_size_log2;
    if (cfg_size_log2 < 3'(SIZE_LOG2_MIN))  size_sat = 3'(SIZE_LOG2_MIN);
    else if (cfg_size_log2 > 3'(SZ_MAX))    size_sat = 3'(SZ_MAX);
  end

  // The first beat of a block uses the live configuration so a block can start
  // in the same cycle the previous one ends.
  assign first_beat = (state_q == ST_IDLE);
  assign bpb_eff    = first_beat ? BPB_W'(beats_per_block(size_sat, LANES)) : bpb_q;
  assign mode_eff   = first_beat ? decode_mode(cfg_mode) : mode_q;
  assign dc_eff     = first_beat ? $signed(in_resid[RW-1:0]) : dc_q;
  assign beat_last  = (cnt_q == bpb_eff - BPB_W'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    state_q <= ST_IDLE;
    else if (flush)  state_q <= ST_IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (accept) state_d = beat_last ? ST_IDLE : ST_ACTIVE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      bpb_q  <= BPB_W'(1);
      mode_q <= MODE_ADD;
      dc_q   <= '0;
    end else if (flush) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= beat_last ? '0 : cnt_q + BPB_W'(1);
      if (first_beat) begin
        bpb_q  <= bpb_eff;
        mode_q <= mode_eff;
        dc_q   <= dc_eff;
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    always_comb begin
      r_eff[l] = $signed(in_resid[l*RW +: RW]);
      if (mode_eff == MODE_SKIP)    r_eff[l] = '0;
      else if (mode_eff == MODE_DC) r_eff[l] = dc_eff;
    end

    recon_clip_lane #(
      .PIXEL_WIDTH    (PW),
      .RESIDUAL_WIDTH (RW)
    ) u_lane (
      .pred    (in_pred[l*PW +: PW]),
      .resid   (r_eff[l]),
      .sum     (sum_d[l]),
      .sum_q   (s1_sum[l]),
      .pix     (pix_d[l]),
      .clipped (clip_d[l])
    );

    assign out_pix[l*PW +: PW] = s2_pix[l];
  end

  always_comb begin
    nclip_d = '0;
    for (int l = 0; l < LANES; l++) nclip_d = nclip_d + NC_W'(clip_d[l]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_nclip <= '0;
      for (int l = 0; l < LANES; l++) begin
        s1_sum[l] <= '0;
        s2_pix[l] <= '0;
      end
    end else if (flush) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
    end else if (adv) begin
      s1_valid <= accept;
      s1_last  <= accept && beat_last;
      s2_valid <= s1_valid;
      s2_last  <= s1_valid && s1_last;
      if (accept) begin
        for (int l = 0; l < LANES; l++) s1_sum[l] <= sum_d[l];
      end
      if (s1_valid) begin
        s2_nclip <= nclip_d;
        for (int l = 0; l < LANES; l++) s2_pix[l] <= pix_d[l];
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_last  = s2_last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q      <= '0;
      done       <= 1'b0;
      clip_count <= '0;
    end else if (flush) begin
      acc_q <= '0;
      done  <= 1'b0;
    end else begin
      done <= out_fire && s2_last;
      if (out_fire) begin
        if (s2_last) begin
          clip_count <= acc_q + 11'(s2_nclip);
          acc_q      <= '0;
        end else begin
          acc_q <= acc_q + 11'(s2_nclip);
        end
      end
    end
  end

endmodule

// File: tb/tb_block_combiner_stream.sv
module tb_block_combiner_stream;
  localparam int LANES = 4;
  localparam int PW    = 8;
  localparam int RW    = 12;
  localparam int PMAX  = 255;

  logic                  clk = 1'b0;
  logic                  reset_n, flush, in_valid, in_ready, out_valid, out_ready, out_last, done;
  logic [2:0]            cfg_size_log2;
  logic [1:0]            cfg_mode;
  logic [LANES*PW-1:0]   in_pred, out_pix;
  logic [LANES*RW-1:0]   in_resid;
  logic [10:0]           clip_count;

  always #5 clk = ~clk;

  block_combiner_stream #(
    .MAX_BLOCK_SIZE (32),
    .LANES          (LANES),
    .PIXEL_WIDTH    (PW),
    .RESIDUAL_WIDTH (RW)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .flush         (flush),
    .cfg_size_log2 (cfg_size_log2),
    .cfg_mode      (cfg_mode),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_pred       (in_pred),
    .in_resid      (in_resid),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pix       (out_pix),
    .out_last      (out_last),
    .done          (done),
    .clip_count    (clip_count)
  );

  typedef struct {
    logic [LANES*PW-1:0] pred;
    logic [LANES*RW-1:0] resid;
    logic [2:0]          sz;
    logic [1:0]          md;
  } beat_t;

  typedef struct {
    logic [LANES*PW-1:0] pix;
    logic                last;
  } obeat_t;

  beat_t  in_q[$];
  obeat_t exp_q[$];
  int     exp_clip[$];
  int     gp[1024];
  int     gr[1024];

  int   n_cmp = 0, n_err = 0;
  int   rdy_mode = 0;
  bit   vrand = 0, tog = 0, flush_now = 0, post_flush = 0;
  bit   done_due = 0, prev_stall = 0, lat_arm = 0;
  int   clip_due = 0, last_clip = 0, stepno = 0, acc_step = -1, n_acc = 0;
  logic [LANES*PW-1:0] prev_pix;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: each pixel is clamp(P + R_eff); DC uses the block's very first residual.
  task automatic push_block(input int szc, input int md);
    int sz, npix, nb, re, v, ncl;
    beat_t  b;
    obeat_t o;
    sz   = (szc < 2) ? 2 : ((szc > 5) ? 5 : szc);
    npix = 1 << (2 * sz);
    nb   = npix / LANES;
    ncl  = 0;
    for (int bi = 0; bi < nb; bi++) begin
      for (int l = 0; l < LANES; l++) begin
        int i;
        i = bi * LANES + l;
        b.pred[l*PW +: PW]  = PW'(gp[i]);
        b.resid[l*RW +: RW] = RW'(gr[i]);
        re = (md == 1) ? 0 : ((md == 2) ? gr[0] : gr[i]);
        v  = gp[i] + re;
        if (v < 0)         begin v = 0;    ncl++; end
        else if (v > PMAX) begin v = PMAX; ncl++; end
        o.pix[l*PW +: PW] = PW'(v);
      end
      if (bi == 0) begin
        b.sz = 3'(szc);
        b.md = 2'(md);
      end else begin
        b.sz = 3'($urandom_range(0, 7));
        b.md = 2'($urandom_range(0, 3));
      end
      o.last = (bi == nb - 1);
      in_q.push_back(b);
      exp_q.push_back(o);
    end
    exp_clip.push_back(ncl);
  endtask

  task automatic step();
    bit fo, fi, new_due;
    obeat_t e;
    @(negedge clk);
    stepno++;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       begin out_ready = !tog; tog = !tog; end
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
    if (in_q.size() > 0 && (!vrand || $urandom_range(0, 3) != 0)) begin
      in_valid      = 1'b1;
      in_pred       = in_q[0].pred;
      in_resid      = in_q[0].resid;
      cfg_size_log2 = in_q[0].sz;
      cfg_mode      = in_q[0].md;
    end else begin
      in_valid      = 1'b0;
      in_pred       = {$urandom, $urandom};
      in_resid      = {$urandom, $urandom};
      cfg_size_log2 = 3'($urandom_range(0, 7));
      cfg_mode      = 2'($urandom_range(0, 3));
    end
    flush = flush_now;
    #1;
    if (post_flush) begin
      chk("flush_out_valid", out_valid, 1'b0);
      chk("flush_out_last", out_last, 1'b0);
      chk("flush_clip_keep", clip_count, last_clip);
      post_flush = 0;
    end
    if (prev_stall) begin
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_pix", out_pix, prev_pix);
    end
    chk("in_ready", in_ready, !out_valid || out_ready);
    chk("done", done, done_due);
    if (done_due) begin
      chk("clip_count", clip_count, clip_due);
      last_clip = clip_due;
    end
    if (lat_arm && acc_step >= 0 && out_valid) begin
      chk("latency", stepno - acc_step, 2);
      lat_arm = 0;
    end
    fo = out_valid && out_ready;
    fi = in_valid && in_ready && !flush;
    new_due = 0;
    if (fo && !flush) begin
      if (exp_q.size() == 0) chk("spurious_out", out_valid, 1'b0);
      else begin
        e = exp_q.pop_front();
        chk("pix", out_pix, e.pix);
        chk("last", out_last, e.last);
        if (e.last && exp_clip.size() > 0) begin
          new_due  = 1;
          clip_due = exp_clip.pop_front();
        end
      end
    end
    done_due   = new_due;
    prev_stall = out_valid && !out_ready && !flush;
    prev_pix   = out_pix;
    if (fi && lat_arm && acc_step < 0) acc_step = stepno;
    @(posedge clk);
    if (fi) begin
      void'(in_q.pop_front());
      n_acc++;
    end
    if (flush) begin
      in_q.delete();
      exp_q.delete();
      exp_clip.delete();
      prev_stall = 0;
      done_due   = 0;
      post_flush = 1;
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((in_q.size() > 0 || exp_q.size() > 0 || done_due) && n < budget) begin
      step();
      n++;
    end
    chk("drain_timeout", (in_q.size() == 0 && exp_q.size() == 0 && !done_due), 1'b1);
  endtask

  function automatic int rnd_res();
    return int'($urandom_range(0, 4095)) - 2048;
  endfunction

  initial begin
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    cfg_size_log2 = '0; cfg_mode = '0; in_pred = '0; in_resid = '0;
    #12;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_out_pix", out_pix, '0);
    chk("rst_clip_count", clip_count, '0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);

    // ADD, size 4, all pixels saturate high
    for (int i = 0; i < 16; i++) begin gp[i] = 200; gr[i] = 100; end
    rdy_mode = 0; lat_arm = 1; acc_step = -1;
    push_block(2, 0);
    drain(200);

    // ADD, size 8, half clip low, half pass
    for (int i = 0; i < 64; i++) begin gp[i] = 10; gr[i] = (i < 32) ? -20 : 5; end
    push_block(3, 0);
    drain(300);

    // DC, size 8, first residual -3, the rest random and ignored
    for (int i = 0; i < 64; i++) begin gp[i] = 100; gr[i] = rnd_res(); end
    gr[0] = -3;
    push_block(3, 2);
    drain(300);

    // SKIP, size 16, full-range residuals ignored
    for (int i = 0; i < 256; i++) begin gp[i] = int'($urandom_range(0, 255)); gr[i] = rnd_res(); end
    push_block(4, 1);
    drain(1000);

    // Back-pressure 1010 on a size-8 ADD block
    for (int i = 0; i < 64; i++) begin gp[i] = int'($urandom_range(0, 255)); gr[i] = rnd_res(); end
    rdy_mode = 1; tog = 0;
    push_block(3, 0);
    drain(500);

    // Flush on beat 5 of a size-8 block, then a fresh size-4 block
    rdy_mode = 0;
    for (int i = 0; i < 64; i++) begin gp[i] = int'($urandom_range(0, 255)); gr[i] = rnd_res(); end
    push_block(3, 0);
    n_acc = 0;
    for (int k = 0; k < 50 && n_acc < 4; k++) step();
    chk("flush_setup", n_acc, 4);
    flush_now = 1;
    step();
    flush_now = 0;
    step();
    for (int i = 0; i < 16; i++) begin gp[i] = int'($urandom_range(200, 255)); gr[i] = rnd_res() / 16; end
    push_block(2, 0);
    drain(200);

    // Random back-to-back blocks: any mode incl. reserved, illegal sizes, random stalls and gaps
    rdy_mode = 2; vrand = 1;
    for (int blk = 0; blk < 6; blk++) begin
      for (int i = 0; i < 1024; i++) begin gp[i] = int'($urandom_range(0, 255)); gr[i] = rnd_res(); end
      push_block(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
    end
    drain(20000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/block_combiner_stream.md
Name: block_combiner_stream

Overview:
Streaming, parametrised successor to the full-array block combiner in the Camera Decoder reconstruction path. It accepts prediction and residual samples LANES pixels per beat in raster order over a valid/ready handshake. Each pixel is reconstructed as clip(P + R) into the pixel range and streamed out with block framing. The block adds runtime block size, three residual modes, back-pressure, flush and per-block saturation statistics.

Parameters:
MAX_BLOCK_SIZE, 32, largest supported block edge; legal runtime sizes are 4, 8, 16, 32 up to this value.
LANES, 4, pixels per beat; power of two, 1..16.
PIXEL_WIDTH, 8, unsigned pixel bits (8..12).
RESIDUAL_WIDTH, 12, signed residual bits; must be greater than PIXEL_WIDTH.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear; drops the block in progress
cfg_size_log2  in  3  block edge log2 (2..5); sampled on the first beat of a block
cfg_mode  in  2  residual mode: 0 ADD, 1 SKIP (R ignored), 2 DC (one residual for the whole block), 3 reserved (treated as ADD)
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid and in_ready are both high
in_pred  in  LANES*PIXEL_WIDTH  prediction pixels; lane 0 in the LSBs
in_resid  in  LANES*RESIDUAL_WIDTH  signed residuals; lane 0 in the LSBs
out_valid  out  1  output beat valid
out_ready  in  1  downstream ready
out_pix  out  LANES*PIXEL_WIDTH  reconstructed pixels
out_last  out  1  marks the final beat of a block
done  out  1  one-cycle pulse when the final output beat is accepted
clip_count  out  11  number of saturated pixels in the completed block; valid while done is high

Behaviour:
- Reset, asynchronous on reset_n low:
  - out_valid, out_last, done = 0; out_pix = 0; clip_count = 0.
  - Beat counter = 0; FSM = IDLE.
  - in_ready = 1 once reset is released.
- FSM states IDLE and ACTIVE.
  - IDLE -> ACTIVE on the first accepted beat.
  - On that beat the block latches cfg_size_log2 and cfg_mode.
  - In DC mode it also latches lane 0 of in_resid as dc_resid.
  - It then computes beats_per_block = (1 << 2*size_log2) / LANES, clamped to a minimum of 1.
  - ACTIVE -> IDLE on acceptance of beat number beats_per_block-1.
  - Configuration inputs are ignored while ACTIVE.
- Illegal cfg_size_log2 values (<2, >5, or above log2 MAX_BLOCK_SIZE) saturate to the nearest legal value.
- Pipeline:
  - Two stages: S1 registers the sums, S2 registers the clipped pixels.
  - Advance condition: adv = !S2_valid || out_ready; in_ready = adv.
  - The pipeline holds fully on stall, and out_pix stays stable while out_valid && !out_ready.
  - Latency is 2 cycles from input acceptance to out_valid when out_ready is held high.
  - Sustained throughput is 1 beat per clock.
- Arithmetic, per lane:
  - sum = signed({0,P}) + R_eff, computed at RESIDUAL_WIDTH+1 bits.
  - R_eff = in_resid lane in ADD, 0 in SKIP, dc_resid in DC. In DC mode every beat uses dc_resid, including the first.
  - Result = 0 if sum < 0; 2^PIXEL_WIDTH-1 if sum exceeds that value; otherwise sum[PIXEL_WIDTH-1:0].
  - A pixel counts as clipped if either saturation branch is taken.
- Statistics:
  - The clip accumulator adds the per-beat clipped-lane count at S2 acceptance.
  - On the last beat the accumulator value including that beat goes to clip_count, and the accumulator then clears.
  - clip_count holds its value until the next done.
- Framing:
  - out_last is carried through the pipeline with the beat.
  - done is asserted on the cycle after out_valid && out_ready && out_last.
- Back-to-back blocks: the beat after a block's last beat may start the next block in the same cycle the FSM returns to IDLE. There are no bubbles.
- flush:
  - Has priority over all other activity.
  - Next cycle: pipeline valids = 0, counter = 0, FSM = IDLE, accumulator = 0, done = 0.
  - clip_count keeps its last value.
  - A beat presented during flush is dropped.
- reset_n asserted mid-block behaves as flush, plus clip_count cleared.

Decomposition:
- Package recon_pkg holds:
  - mode enum {MODE_ADD, MODE_SKIP, MODE_DC};
  - function beats_per_block(size_log2, lanes);
  - function pix_max(PIXEL_WIDTH).
- Sub-module recon_clip_lane: single-lane, purely combinational add, clip and clip flag. The top level instantiates it LANES times inside S1/S2.

Test Plan:
- ADD, size 4, LANES 4, P=200 and R=+100 on all pixels -> 4 beats of 255, out_last on beat 4, done pulse, clip_count=16.
- ADD, size 8, P=10 and R=-20 on half the pixels, R=+5 on the rest -> pixels 0 and 15, clip_count=32.
- DC, size 8, first-beat lane-0 R=-3, other residuals random, P=100 -> all 64 pixels = 97.
- SKIP, size 16, random P and R with R at full range -> out_pix == P for every pixel, clip_count=0.
- Back-pressure: out_ready toggling 1010 during a size-8 block -> no data loss or duplication, out_pix stable while stalled, in_ready follows adv.
- flush on beat 5 of a size-8 block, then a new size-4 block -> no out_last or done for the aborted block; the new block completes with correct pixels and its own clip_count.
